// File: rtl/hw_priority_drain_encoder.sv
// hw_priority_drain_encoder: registered priority encoder that drains a latched request vector, highest index first
//
// Optional feature macro: HW_PENC_STATS_EN (adds pend_cnt and batch_done)
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_in          request vector (2**N bits), latched on acceptance
//   req_valid       req_in valid
//   req_ready       block is idle and can accept a vector
//   grant_idx       binary index of the highest pending bit
//   grant_onehot    one-hot of grant_idx, zero when no grant is valid
//   grant_valid     grant_idx/grant_onehot valid
//   grant_ready     consumer accepts the current grant
//   pend_cnt        (stats) popcount of the pending vector
//   batch_done      (stats) pulse the cycle after the last grant is accepted
//   err_zero        pulse: the accepted vector was all zero
module hw_priority_drain_encoder #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [(2**N)-1:0]   req_in,
    input  logic                req_valid,
    output logic                req_ready,
    output logic [N-1:0]        grant_idx,
    output logic [(2**N)-1:0]   grant_onehot,
    output logic                grant_valid,
    input  logic                grant_ready,
`ifdef HW_PENC_STATS_EN
    output logic [N:0]          pend_cnt,
    output logic                batch_done,
`endif
    output logic                err_zero
);
    localparam int W = 2**N;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] pending_q, pending_d;
    logic         err_zero_q, err_zero_d;
    // Holds req_ready low while in reset and until the first edge after release.
    logic         alive_q;
    logic         accept, take;

    // pending is always zero in IDLE, so the idle index naturally encodes as 0.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < W; i++)
            if (pending_q[i]) grant_idx = N'(i);
    end

    assign grant_valid  = state_q == DRAIN;
    assign grant_onehot = grant_valid ? W'(1) << grant_idx : '0;
    assign req_ready    = alive_q && state_q == IDLE;
    assign err_zero     = err_zero_q;
    assign accept       = req_ready && req_valid;
    assign take         = grant_valid && grant_ready;

    always_comb begin
        pending_d  = pending_q;
        state_d    = state_q;
        err_zero_d = 1'b0;
        if (accept) begin
            pending_d  = req_in;
            state_d    = |req_in ? DRAIN : IDLE;
            err_zero_d = ~|req_in;
        end else if (take) begin
            pending_d = pending_q & ~grant_onehot;
            state_d   = |pending_d ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            err_zero_q <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            err_zero_q <= err_zero_d;
            alive_q    <= 1'b1;
        end
    end

`ifdef HW_PENC_STATS_EN
    logic [N:0] pend_cnt_q, pend_cnt_d;
    logic       batch_done_q, batch_done_d;

    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < W; i++)
            pend_cnt_d = pend_cnt_d + (N+1)'(pending_d[i]);
        batch_done_d = take && ~|pending_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt_q   <= '0;
            batch_done_q <= 1'b0;
        end else begin
            pend_cnt_q   <= pend_cnt_d;
            batch_done_q <= batch_done_d;
        end
    end

    assign pend_cnt   = pend_cnt_q;
    assign batch_done = batch_done_q;
`endif
endmodule

// File: tb/tb_hw_priority_drain_encoder.sv
// tb_hw_priority_drain_encoder: directed self-checking bench for hw_priority_drain_encoder with N=3
module tb_hw_priority_drain_encoder;
    localparam int N = 3;
    localparam int W = 2**N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] req_in = '0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [N-1:0] grant_idx;
    logic [W-1:0] grant_onehot;
    logic         grant_valid;
    logic         grant_ready = 1'b0;
    logic         err_zero;
`ifdef HW_PENC_STATS_EN
    logic [N:0]   pend_cnt;
    logic         batch_done;
    int           done_seen;
`endif
    int total = 0;
    int bad = 0;

    hw_priority_drain_encoder #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_in(req_in),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .grant_idx(grant_idx),
        .grant_onehot(grant_onehot),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready),
`ifdef HW_PENC_STATS_EN
        .pend_cnt(pend_cnt),
        .batch_done(batch_done),
`endif
        .err_zero(err_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({req_ready, grant_valid, grant_idx, grant_onehot, err_zero} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b gv=%b idx=%0d oh=%h ez=%b want all 0", req_ready, grant_valid, grant_idx, grant_onehot, err_zero);
        end
`ifdef HW_PENC_STATS_EN
        total++;
        if ({pend_cnt, batch_done} !== '0) begin
            bad++;
            $display("FAIL reset_stats: cnt=%0d bd=%b want 0", pend_cnt, batch_done);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b1 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: rdy=%b gv=%b want rdy=1 gv=0", req_ready, grant_valid);
        end
    endtask

    task automatic test_drain_94();
        logic [N-1:0] exp_idx [3] = '{3'd7, 3'd4, 3'd2};
        logic [W-1:0] exp_oh [3] = '{8'h80, 8'h10, 8'h04};
        req_in = 8'h94;
        req_valid = 1'b1;
        grant_ready = 1'b1;
        tick();
        req_valid = 1'b0;
`ifdef HW_PENC_STATS_EN
        done_seen = 0;
`endif
        for (int k = 0; k < 3; k++) begin
            total++;
            if (grant_valid !== 1'b1 || grant_idx !== exp_idx[k] || grant_onehot !== exp_oh[k] || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL drain94_grant%0d: gv=%b idx=%0d oh=%h rdy=%b want gv=1 idx=%0d oh=%h rdy=0", k, grant_valid, grant_idx, grant_onehot, req_ready, exp_idx[k], exp_oh[k]);
            end
`ifdef HW_PENC_STATS_EN
            total++;
            if (pend_cnt !== 4'(3 - k)) begin
                bad++;
                $display("FAIL drain94_cnt%0d: cnt=%0d want %0d", k, pend_cnt, 3 - k);
            end
            if (batch_done) done_seen++;
`endif
            tick();
        end
        total++;
        if (req_ready !== 1'b1 || grant_valid !== 1'b0 || grant_onehot !== 8'h00) begin
            bad++;
            $display("FAIL drain94_idle: rdy=%b gv=%b oh=%h want rdy=1 gv=0 oh=00", req_ready, grant_valid, grant_onehot);
        end
`ifdef HW_PENC_STATS_EN
        if (batch_done) done_seen++;
        total++;
        if (pend_cnt !== 4'd0 || batch_done !== 1'b1) begin
            bad++;
            $display("FAIL drain94_stats_end: cnt=%0d bd=%b want cnt=0 bd=1", pend_cnt, batch_done);
        end
        tick();
        if (batch_done) done_seen++;
        total++;
        if (done_seen != 1) begin
            bad++;
            $display("FAIL drain94_batch_done: pulses=%0d want 1", done_seen);
        end
`endif
    endtask

    task automatic test_backpressure();
        req_in = 8'h21;
        req_valid = 1'b1;
        grant_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (grant_valid !== 1'b1 || grant_idx !== 3'd5 || grant_onehot !== 8'h20) begin
                bad++;
                $display("FAIL hold_idx5_c%0d: gv=%b idx=%0d oh=%h want gv=1 idx=5 oh=20", k, grant_valid, grant_idx, grant_onehot);
            end
            if (k < 3) tick();
        end
        grant_ready = 1'b1;
        tick();
        total++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_onehot !== 8'h01 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bit0_grant: gv=%b idx=%0d oh=%h rdy=%b want gv=1 idx=0 oh=01 rdy=0", grant_valid, grant_idx, grant_onehot, req_ready);
        end
        tick();
        total++;
        if (grant_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bit0_idle: gv=%b rdy=%b want gv=0 rdy=1", grant_valid, req_ready);
        end
    endtask

    task automatic test_zero_vector();
        req_in = 8'h00;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        total++;
        if (err_zero !== 1'b1 || grant_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL zero_pulse: ez=%b gv=%b rdy=%b want ez=1 gv=0 rdy=1", err_zero, grant_valid, req_ready);
        end
        tick();
        total++;
        if (err_zero !== 1'b0 || grant_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL zero_after: ez=%b gv=%b rdy=%b want ez=0 gv=0 rdy=1", err_zero, grant_valid, req_ready);
        end
    endtask

    task automatic test_ignore_req_in_drain();
        req_in = 8'hC0;
        req_valid = 1'b1;
        grant_ready = 1'b1;
        tick();
        req_in = 8'hFF;
        total++;
        if (grant_idx !== 3'd7 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL ign_g7: gv=%b idx=%0d want gv=1 idx=7", grant_valid, grant_idx);
        end
        tick();
        total++;
        if (grant_idx !== 3'd6 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL ign_g6: gv=%b idx=%0d want gv=1 idx=6", grant_valid, grant_idx);
        end
        tick();
        req_valid = 1'b0;
        total++;
        if (grant_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL ign_idle: gv=%b rdy=%b want gv=0 rdy=1", grant_valid, req_ready);
        end
        tick();
        total++;
        if (grant_valid !== 1'b0 || grant_onehot !== 8'h00) begin
            bad++;
            $display("FAIL ign_no_reload: gv=%b oh=%h want gv=0 oh=00", grant_valid, grant_onehot);
        end
    endtask

    task automatic test_reset_mid_drain();
        req_in = 8'hFF;
        req_valid = 1'b1;
        grant_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        total++;
        if (grant_idx !== 3'd6 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: gv=%b idx=%0d want gv=1 idx=6", grant_valid, grant_idx);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (grant_valid !== 1'b0 || grant_onehot !== 8'h00 || grant_idx !== 3'd0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_async: gv=%b oh=%h idx=%0d rdy=%b want all 0", grant_valid, grant_onehot, grant_idx, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b1 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_release: rdy=%b gv=%b want rdy=1 gv=0", req_ready, grant_valid);
        end
        tick();
        total++;
        if (grant_valid !== 1'b0 || grant_onehot !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_empty: gv=%b oh=%h want gv=0 oh=00", grant_valid, grant_onehot);
        end
`ifdef HW_PENC_STATS_EN
        total++;
        if (pend_cnt !== 4'd0) begin
            bad++;
            $display("FAIL rst_mid_cnt: cnt=%0d want 0", pend_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_drain_94();
        test_backpressure();
        test_zero_vector();
        test_ignore_req_in_drain();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
